axis_frame_gen: RTL and testbench
=================================

Name: axis_frame_gen

Overview:
- Single-clock AXI-Stream frame source. Drives fixed-length frames with a deterministic counting payload into the slave side of axis_async_fifo_wrapper or any AXIS sink.
- Acts as the pause responder: honours pause_req only at frame boundaries.
- Used as a traffic source for FIFO bring-up, throughput tests and frame-drop tests.

Parameters:
MAX_LEN, 256, maximum frame length in beats; must be >= 1
LEN_WIDTH, $clog2(MAX_LEN)+1, width of frame_len
TDATA_WIDTH, TUSER_WIDTH and the other widths are taken from tx_axis_if; TDATA_WIDTH must be > 0 (initial assertion)

Ports:
clk  input  1  block clock
reset_n  input  1  asynchronous active-low reset
tx_axis_if  AXIS_IF.Master  interface  generated stream
start  input  1  one-cycle pulse; begins a run; ignored while busy=1
stop  input  1  one-cycle pulse; ends the run at the next frame boundary
frame_len  input  LEN_WIDTH  beats per frame; sampled on accepted start
frame_count  input  16  frames per run; 0 = continuous until stop
pause_req  input  1  pause request
pause_ack  output  1  paused at a frame boundary
busy  output  1  run in progress (SEND or PAUSED)
frames_sent  output  32  frames completed since reset; wraps modulo 2^32

Behaviour:
Clock and reset:
- One clock. Reset is asynchronous, active-low (reset_n).
- On reset: state=IDLE; tvalid=0; tlast=0; tdata=0; tuser=0; pause_ack=0; busy=0; frames_sent=0; word counter=0; stop_pending=0.

Constant outputs:
- tkeep all ones; tid=0; tdest=0; tstrb='0; twakeup=0.
- All AXIS outputs are registered.

States (IDLE, SEND, PAUSED):
- IDLE: tvalid=0; pause_ack=0.
  - Accepted start latches len = clamp(frame_len) and rem = frame_count, and clears the word counter.
  - Then goes to PAUSED if pause_req=1, else to SEND.
  - Clamp: frame_len=0 is treated as 1; frame_len>MAX_LEN is treated as MAX_LEN.
  - tvalid first rises the cycle after start.
- SEND: tvalid=1.
  - tdata = word counter, zero-extended or truncated to TDATA_WIDTH.
  - tlast=1 when beat index == len-1.
  - On tvalid&&tready: increment the word counter and the beat index.
  - Outputs stay stable while tready=0 (AXIS rule). tvalid never drops mid-frame.
- Frame end (handshake with tlast=1):
  - Increment frames_sent.
  - If frame_count!=0, decrement rem.
  - Then, in priority order:
    - rem reaches 0 (finite run) or stop_pending=1: go to IDLE and clear stop_pending.
    - pause_req=1: go to PAUSED.
    - Otherwise start the next frame back-to-back with no idle cycle.
- PAUSED: tvalid=0; pause_ack=1 from the cycle after entry. When pause_req=0, return to SEND the next cycle; pause_ack drops in that same cycle.
- stop while busy sets stop_pending. A frame is never truncated.
- stop in PAUSED: go to IDLE immediately.
- start and stop together while IDLE: start is taken and stop_pending is set, so exactly one frame is sent.
- pause_req asserted mid-frame: the frame completes first.
- Reset mid-frame: the frame is abandoned. The sink sees tvalid drop without tlast; this is accepted.
- Single-beat frames (len=1): tlast=1 on every beat.

Optional Feature:
Macro: AXIS_FRAME_GEN_BAD_INJECT_EN
- Defined:
  - Adds input port inject_bad (1 bit).
  - A pulse while busy arms a flag. On the last beat of the current frame (or of the next frame if issued in PAUSED), tuser[0]=1 to match the FIFO's default USER_BAD_FRAME_VALUE/MASK. The flag then clears.
  - tuser=0 on all other beats.
  - Initial assertion: TUSER_WIDTH>0.
- Undefined: the port is absent and tuser is tied to 0.

Test Plan:
1. frame_len=4, frame_count=2, tready=1 -> 8 contiguous beats, tdata 0..7, tlast on beats 3 and 7; busy=0 afterwards; frames_sent=2.
2. frame_len=3, tready toggling 1/0 every cycle -> tdata/tlast held while tready=0; beats 0,1,2 and 3,4,5 with tlast on words 2 and 5; no beat lost or duplicated.
3. frame_count=0, frame_len=5, stop on the cycle after beat 2 -> current frame completes with tlast at word 4; IDLE next cycle; frames_sent=1.
4. pause_req raised at beat 1 of a 4-beat frame -> beats 2,3 sent, then pause_ack=1 with tvalid=0. Drop pause_req -> next frame starts at tdata 4.
5. frame_len=0 and frame_len=MAX_LEN+7 -> 1-beat frames (tlast every beat) and MAX_LEN-beat frames respectively.
6. AXIS_FRAME_GEN_BAD_INJECT_EN defined, inject_bad mid-frame 1 of 2 into axis_async_fifo_wrapper with FRAME_FIFO=1, DROP_BAD_FRAME=1 -> rx_status_bad_frame pulses once; only frame 2 appears at the FIFO output.

Source files
------------

// File: rtl/axis_frame_gen.sv
// rtl/axis_frame_gen.sv - fixed-length counting-payload AXI-Stream frame source with pause/stop control
// Optional bad-frame marking on tuser[0] is enabled by defining AXIS_FRAME_GEN_BAD_INJECT_EN.
module axis_frame_gen #(
  parameter int MAX_LEN     = 256,
  parameter int LEN_WIDTH   = $clog2(MAX_LEN) + 1,
  parameter int TDATA_WIDTH = 8,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int KEEP_WIDTH  = (TDATA_WIDTH + 7) / 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic [TDATA_WIDTH-1:0] tdata,
  output logic [KEEP_WIDTH-1:0]  tkeep,
  output logic [KEEP_WIDTH-1:0]  tstrb,
  output logic                   tvalid,
  input  logic                   tready,
  output logic                   tlast,
  output logic [TUSER_WIDTH-1:0] tuser,
  output logic [TID_WIDTH-1:0]   tid,
  output logic [TDEST_WIDTH-1:0] tdest,
  output logic                   twakeup,
`ifdef AXIS_FRAME_GEN_BAD_INJECT_EN
  input  logic                   inject_bad,
`endif
  input  logic                   start,
  input  logic                   stop,
  input  logic [LEN_WIDTH-1:0]   frame_len,
  input  logic [15:0]            frame_count,
  input  logic                   pause_req,
  output logic                   pause_ack,
  output logic                   busy,
  output logic [31:0]            frames_sent
);

  if (TDATA_WIDTH <= 0) begin : g_chk_tdata
    $error("axis_frame_gen: TDATA_WIDTH must be > 0");
  end
  if (MAX_LEN < 1) begin : g_chk_len
    $error("axis_frame_gen: MAX_LEN must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, SEND, PAUSED} state_t;

  state_t               state, state_n;
  logic [LEN_WIDTH-1:0] len, len_n, beat, beat_n;
  logic [15:0]          rem, rem_n;
  logic                 cont, cont_n;
  logic [31:0]          word, word_n, frames_n;
  logic                 stop_pending, stop_pending_n;
  logic                 pause_ack_n, tlast_n, hs;

  function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] l);
    if (l == '0) return LEN_WIDTH'(1);
    if (l > LEN_WIDTH'(MAX_LEN)) return LEN_WIDTH'(MAX_LEN);
    return l;
  endfunction

  assign hs      = tvalid & tready;
  assign busy    = (state != IDLE);
  assign tkeep   = '1;
  assign tstrb   = '0;
  assign tid     = '0;
  assign tdest   = '0;
  assign twakeup = 1'b0;

  always_comb begin
    state_n        = state;
    len_n          = len;
    rem_n          = rem;
    cont_n         = cont;
    word_n         = word;
    beat_n         = beat;
    frames_n       = frames_sent;
    stop_pending_n = stop_pending;
    case (state)
      IDLE: begin
        if (start) begin
          len_n          = clamp_len(frame_len);
          rem_n          = frame_count;
          cont_n         = (frame_count == 16'd0);
          word_n         = '0;
          beat_n         = '0;
          stop_pending_n = stop;
          state_n        = pause_req ? PAUSED : SEND;
        end
      end
      SEND: begin
        if (stop) stop_pending_n = 1'b1;
        if (hs) begin
          word_n = word + 32'd1;
          if (tlast) begin
            frames_n = frames_sent + 32'd1;
            beat_n   = '0;
            if (!cont) rem_n = rem - 16'd1;
            // Finishing the run outranks pausing; a stop arriving on the last beat counts too.
            if ((!cont && rem == 16'd1) || stop_pending || stop) begin
              state_n        = IDLE;
              stop_pending_n = 1'b0;
            end else if (pause_req) begin
              state_n = PAUSED;
            end
          end else begin
            beat_n = beat + LEN_WIDTH'(1);
          end
        end
      end
      PAUSED: begin
        if (stop) begin
          state_n        = IDLE;
          stop_pending_n = 1'b0;
        end else if (!pause_req) begin
          state_n = SEND;
        end
      end
      default: state_n = IDLE;
    endcase
    pause_ack_n = (state == PAUSED) && (state_n == PAUSED);
    tlast_n     = (state_n == SEND) && (beat_n == len_n - LEN_WIDTH'(1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      len          <= LEN_WIDTH'(1);
      rem          <= '0;
      cont         <= 1'b0;
      word         <= '0;
      beat         <= '0;
      frames_sent  <= '0;
      stop_pending <= 1'b0;
      pause_ack    <= 1'b0;
      tvalid       <= 1'b0;
      tlast        <= 1'b0;
      tdata        <= '0;
    end else begin
      state        <= state_n;
      len          <= len_n;
      rem          <= rem_n;
      cont         <= cont_n;
      word         <= word_n;
      beat         <= beat_n;
      frames_sent  <= frames_n;
      stop_pending <= stop_pending_n;
      pause_ack    <= pause_ack_n;
      tvalid       <= (state_n == SEND);
      tlast        <= tlast_n;
      tdata        <= TDATA_WIDTH'(word_n);
    end
  end

`ifdef AXIS_FRAME_GEN_BAD_INJECT_EN
  if (TUSER_WIDTH <= 0) begin : g_chk_tuser
    $error("axis_frame_gen: TUSER_WIDTH must be > 0 with bad-frame injection");
  end

  logic                   armed, armed_n;
  logic [TUSER_WIDTH-1:0] tuser_n;

  always_comb begin
    armed_n = armed;
    if (hs && tlast && tuser[0]) armed_n = 1'b0;
    if (inject_bad && busy) armed_n = 1'b1;
    if (state_n == IDLE) armed_n = 1'b0;
    // A stalled beat keeps its tuser; a late request then marks the following frame.
    if (tvalid && !tready) begin
      tuser_n = tuser;
    end else begin
      tuser_n    = '0;
      tuser_n[0] = armed_n && tlast_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed <= 1'b0;
      tuser <= '0;
    end else begin
      armed <= armed_n;
      tuser <= tuser_n;
    end
  end
`else
  assign tuser = '0;
`endif

endmodule

// File: tb/tb_axis_frame_gen.sv
// tb/tb_axis_frame_gen.sv - self-checking bench for axis_frame_gen against a beat-list reference model
module tb_axis_frame_gen;
  localparam int MAX_LEN     = 16;
  localparam int LEN_WIDTH   = $clog2(MAX_LEN) + 1;
  localparam int TDATA_WIDTH = 8;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic [TDATA_WIDTH-1:0] tdata;
  logic [0:0]             tkeep, tstrb, tuser, tid, tdest;
  logic                   tvalid, tlast, twakeup;
  logic                   tready;
  logic                   start = 1'b0, stop = 1'b0, pause_req = 1'b0;
  logic [LEN_WIDTH-1:0]   frame_len = '0;
  logic [15:0]            frame_count = '0;
  logic                   pause_ack, busy;
  logic [31:0]            frames_sent;

  axis_frame_gen #(
    .MAX_LEN(MAX_LEN), .TDATA_WIDTH(TDATA_WIDTH), .TUSER_WIDTH(1), .TID_WIDTH(1), .TDEST_WIDTH(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .tdata(tdata), .tkeep(tkeep), .tstrb(tstrb), .tvalid(tvalid), .tready(tready),
    .tlast(tlast), .tuser(tuser), .tid(tid), .tdest(tdest), .twakeup(twakeup),
    .start(start), .stop(stop), .frame_len(frame_len), .frame_count(frame_count),
    .pause_req(pause_req), .pause_ack(pause_ack), .busy(busy), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // 0: always ready, 1: toggle every cycle, 2: random ~75% ready
  int tready_mode = 0;
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (tready_mode)
        0:       tready = 1'b1;
        1:       tready = ~tready;
        default: tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  typedef struct { int data; bit last; } beat_t;
  beat_t got[$];
  int    got_cyc[$];
  int    cyc = 0;
  int    stall_errs = 0;
  logic  prev_stall = 1'b0;
  logic [TDATA_WIDTH-1:0] prev_data = '0;
  logic  prev_last = 1'b0;

  always @(negedge clk) begin
    beat_t b;
    cyc++;
    if (reset_n) begin
      if (prev_stall && (!tvalid || tdata !== prev_data || tlast !== prev_last)) stall_errs++;
      if (tvalid && tready) begin
        b.data = int'(tdata);
        b.last = tlast;
        got.push_back(b);
        got_cyc.push_back(cyc);
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Reference: a run is frames*len beats of a counting word starting at 0, tlast on each len-th beat.
  beat_t exp_q[$];

  function automatic int clamp(input int l);
    if (l == 0) return 1;
    if (l > MAX_LEN) return MAX_LEN;
    return l;
  endfunction

  task automatic build_model(input int flen, input int frames);
    int len;
    int w;
    len = clamp(flen);
    w = 0;
    exp_q.delete();
    for (int f = 0; f < frames; f++) begin
      for (int b = 0; b < len; b++) begin
        beat_t x;
        x.data = w % (1 << TDATA_WIDTH);
        x.last = (b == len - 1);
        exp_q.push_back(x);
        w++;
      end
    end
  endtask

  task automatic compare_stream(input string name);
    int bad;
    bad = 0;
    check({name, "_beats"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i].data != exp_q[i].data || got[i].last != exp_q[i].last) bad++;
    check({name, "_payload_errs"}, bad, 0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    if (busy) check({name, "_idle_timeout"}, 1, 0);
  endtask

  task automatic start_run(input int flen, input int fcount);
    got.delete();
    got_cyc.delete();
    frame_len   = LEN_WIDTH'(flen);
    frame_count = 16'(fcount);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  typedef struct { int flen; int fcount; int mode; int exp_beats; int exp_frames; } vec_t;

  initial begin
    vec_t        tbl[6];
    logic [31:0] fs0;
    int          n;
    int          flen, fc;

    tbl[0] = '{4, 2, 0, 8, 2};
    tbl[1] = '{3, 2, 1, 6, 2};
    tbl[2] = '{0, 3, 0, 3, 3};
    tbl[3] = '{MAX_LEN + 7, 1, 0, MAX_LEN, 1};
    tbl[4] = '{MAX_LEN, 2, 2, 2 * MAX_LEN, 2};
    tbl[5] = '{1, 4, 2, 4, 4};

    repeat (3) tick();
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tuser", tuser, 0);
    check("rst_tkeep", tkeep, 1);
    check("rst_busy", busy, 0);
    check("rst_pause_ack", pause_ack, 0);
    check("rst_frames_sent", frames_sent, 0);
    reset_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      tready_mode = tbl[i].mode;
      fs0 = frames_sent;
      check("tvalid_before_start", tvalid, 0);
      start_run(tbl[i].flen, tbl[i].fcount);
      check("tvalid_after_start", tvalid, 1);
      wait_idle("table", 500);
      build_model(tbl[i].flen, tbl[i].fcount);
      compare_stream("table");
      check("table_beat_count", got.size(), tbl[i].exp_beats);
      check("table_frames", frames_sent - fs0, tbl[i].exp_frames);
      if (tbl[i].mode == 0 && got_cyc.size() > 0)
        check("table_back_to_back", got_cyc[got_cyc.size() - 1] - got_cyc[0], got_cyc.size() - 1);
    end

    // Continuous run stopped mid-frame; a second start while busy is ignored.
    tready_mode = 0;
    fs0 = frames_sent;
    start_run(5, 0);
    frame_len = LEN_WIDTH'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (tdata != 8'd3 && n < 20) begin tick(); n++; end
    check("stop_reach_beat3", tdata, 3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle("stop", 50);
    build_model(5, 1);
    compare_stream("stop");
    check("stop_frames", frames_sent - fs0, 1);

    // Pause raised at beat 1 of a 4-beat frame.
    start_run(4, 2);
    tick();
    pause_req = 1'b1;
    n = 0;
    while (tvalid && n < 20) begin tick(); n++; end
    check("pause_tvalid_drop", tvalid, 0);
    check("pause_ack_entry_cycle", pause_ack, 0);
    check("pause_beats_before", got.size(), 4);
    tick();
    check("pause_ack_set", pause_ack, 1);
    tick(); tick();
    check("pause_hold_ack", pause_ack, 1);
    check("pause_hold_tvalid", tvalid, 0);
    check("pause_hold_beats", got.size(), 4);
    pause_req = 1'b0;
    tick();
    check("resume_ack_drop", pause_ack, 0);
    check("resume_tvalid", tvalid, 1);
    check("resume_tdata", tdata, 4);
    wait_idle("pause", 50);
    build_model(4, 2);
    compare_stream("pause");

    // Stop while paused returns to idle at once with nothing sent.
    pause_req = 1'b1;
    start_run(3, 0);
    check("paused_start_busy", busy, 1);
    check("paused_start_tvalid", tvalid, 0);
    tick();
    check("paused_start_ack", pause_ack, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("paused_stop_busy", busy, 0);
    check("paused_stop_ack", pause_ack, 0);
    pause_req = 1'b0;
    tick();
    check("paused_stop_beats", got.size(), 0);

    // Start and stop together: exactly one frame.
    stop = 1'b1;
    start_run(3, 0);
    stop = 1'b0;
    wait_idle("start_stop", 50);
    build_model(3, 1);
    compare_stream("start_stop");

    // Randomized runs against the reference model.
    tready_mode = 2;
    for (int r = 0; r < 20; r++) begin
      flen = $urandom_range(0, MAX_LEN + 10);
      fc   = $urandom_range(1, 3);
      fs0  = frames_sent;
      start_run(flen, fc);
      wait_idle("rand", 2000);
      build_model(flen, fc);
      compare_stream("rand");
      check("rand_frames", frames_sent - fs0, fc);
    end
    check("hold_while_stalled", stall_errs, 0);

    // Reset mid-frame abandons the frame.
    tready_mode = 0;
    start_run(8, 0);
    tick(); tick();
    reset_n = 1'b0;
    #1;
    check("midrst_tvalid", tvalid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frames_sent", frames_sent, 0);
    check("midrst_tlast", tlast, 0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
